// File: rtl/hs_stream_serializer_pkg.sv
// Shared definitions for the wide-to-narrow stream serializer: FSM encoding
// and the parameter sanity helpers used at elaboration.
package hs_stream_serializer_pkg;

    // IDLE: nothing held, ready for a word. SEND: a word is held and its
    // beats are being presented downstream.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // The upstream word must split exactly into RATIO beats, with at least two beats.
    function automatic bit widths_consistent(input int in_w, input int out_w, input int ratio);
        return (in_w == ratio * out_w) && (ratio >= 2);
    endfunction

    // Minimum width needed to index RATIO slices.
    function automatic int slice_idx_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/hs_stream_serializer.sv
// Pops IN_WIDTH words from a valid/ready source and emits them as RATIO
// OUT_WIDTH beats, least-significant slice first. Each beat is tagged with
// "last beat of word" and "last beat of frame"; a frame is cfg_words words.
//
// Handshake rules on both ports: a transfer happens on a rising clk edge
// where valid and ready are both high. Once out_vld rises it stays high, with
// out_data stable, until the beat transfers. in_rdy depends combinationally
// on out_rdy so a new word can load in the same cycle the last beat leaves.
module hs_stream_serializer
    import hs_stream_serializer_pkg::*;
#(
    parameter int IN_WIDTH   = 256,
    parameter int OUT_WIDTH  = 32,
    parameter int RATIO      = 8,
    parameter int log2_RATIO = 3,
    parameter int FRM_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FRM_W-1:0]     cfg_words,
    input  logic                 in_vld,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_rdy,
    output logic                 out_vld,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_word_last,
    output logic                 out_frame_last,
    input  logic                 out_rdy,
    output logic                 busy
);

    localparam bit WIDTHS_OK = widths_consistent(IN_WIDTH, OUT_WIDTH, RATIO);
    localparam logic [log2_RATIO-1:0] LAST_BEAT = log2_RATIO'(RATIO - 1);

    if (!WIDTHS_OK || (log2_RATIO < slice_idx_w(RATIO))) begin : g_bad_params
        $error("hs_stream_serializer: IN_WIDTH must equal RATIO*OUT_WIDTH, RATIO>=2, log2_RATIO wide enough");
    end

    state_t                state;
    state_t                state_nx;
    logic [IN_WIDTH-1:0]   hold;
    logic                  hold_final;
    logic [log2_RATIO-1:0] beat_cnt;
    logic [FRM_W-1:0]      word_cnt;
    logic [FRM_W-1:0]      frame_len;
    logic [FRM_W-1:0]      len_eff;
    logic                  on_last_beat;
    logic                  word_is_final;
    logic                  in_fire;
    logic                  out_fire;

    assign on_last_beat = (state == SEND) && (beat_cnt == LAST_BEAT);
    assign in_fire      = in_vld && in_rdy;
    assign out_fire     = out_vld && out_rdy;

    // Frame length is captured only when the first word of a frame is taken;
    // a zero request is treated as one word per frame.
    always_comb begin
        len_eff = frame_len;
        if (word_cnt == '0) begin
            len_eff = (cfg_words == '0) ? FRM_W'(1) : cfg_words;
        end
        word_is_final = ((word_cnt + FRM_W'(1)) == len_eff);
    end

    // Next-state logic and handshake/beat outputs.
    always_comb begin
        state_nx       = state;
        in_rdy         = 1'b0;
        out_vld        = 1'b0;
        out_data       = '0;
        out_word_last  = 1'b0;
        out_frame_last = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_fire) state_nx = SEND;
            end
            SEND: begin
                out_vld        = 1'b1;
                out_data       = hold[int'(beat_cnt) * OUT_WIDTH +: OUT_WIDTH];
                in_rdy         = on_last_beat && out_rdy;
                out_word_last  = on_last_beat;
                out_frame_last = on_last_beat && hold_final;
                if (out_fire && on_last_beat && !in_fire) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == SEND) || (word_cnt != '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Hold register, beat counter and frame bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            hold_final <= 1'b0;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            frame_len  <= '0;
        end else if (in_fire) begin
            hold       <= in_data;
            hold_final <= word_is_final;
            beat_cnt   <= '0;
            frame_len  <= len_eff;
            word_cnt   <= word_is_final ? '0 : word_cnt + FRM_W'(1);
        end else if (out_fire && !on_last_beat) begin
            beat_cnt   <= beat_cnt + log2_RATIO'(1);
        end
    end

endmodule

// File: tb/tb_hs_stream_serializer.sv
// Bench for hs_stream_serializer: a queue of expected beats is built from
// every accepted word, and each cycle the DUT outputs are compared with it.
// Directed scenarios add literal checks on the logged beat stream.
module tb_hs_stream_serializer;

    localparam int IW = 256;
    localparam int OW = 32;
    localparam int R  = 8;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] cfg_words = '0;
    logic          in_vld = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_rdy;
    logic          out_vld;
    logic [OW-1:0] out_data;
    logic          out_word_last;
    logic          out_frame_last;
    logic          out_rdy = 1'b0;
    logic          busy;

    hs_stream_serializer #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .RATIO(R), .log2_RATIO(3), .FRM_W(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_words(cfg_words),
        .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_data(out_data),
        .out_word_last(out_word_last), .out_frame_last(out_frame_last),
        .out_rdy(out_rdy), .busy(busy)
    );

    // clock
    always #5 clk = ~clk;

    // model: expected beats {frame_last, word_last, data}, frame word count
    logic [OW+1:0] exp_q[$];
    int            m_wcnt = 0;
    int            m_flen = 0;

    // logs of transfers seen during directed scenarios
    logic [OW-1:0] obs_d[$];
    logic          obs_wl[$];
    logic          obs_fl[$];
    int            obs_cyc[$];
    int            acc_cyc[$];
    int            cyc = 0;
    logic          last_in_fire = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [IW-1:0] rnd_word();
        logic [IW-1:0] w;
        for (int i = 0; i < R; i++) w[i*OW +: OW] = $urandom;
        return w;
    endfunction

    function automatic logic [IW-1:0] idx_word(input int base);
        logic [IW-1:0] w;
        for (int i = 0; i < R; i++) w[i*OW +: OW] = OW'(base + i);
        return w;
    endfunction

    task automatic clear_logs();
        obs_d.delete(); obs_wl.delete(); obs_fl.delete();
        obs_cyc.delete(); acc_cyc.delete();
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic step(input logic iv, input logic [IW-1:0] id, input logic ordy, input logic [FW-1:0] cfg);
        logic          e_vld, e_rdy, e_busy, o_f, i_f, fin;
        logic [OW+1:0] e_front;
        int            len;
        @(negedge clk);
        in_vld = iv; in_data = id; out_rdy = ordy; cfg_words = cfg;
        #1;
        e_vld   = (exp_q.size() != 0);
        e_front = e_vld ? exp_q[0] : '0;
        e_rdy   = !e_vld || (exp_q.size() == 1 && ordy);
        e_busy  = e_vld || (m_wcnt != 0);
        chk("out_vld", 64'(out_vld), 64'(e_vld));
        if (e_vld) chk("out_data", 64'(out_data), 64'(e_front[OW-1:0]));
        chk("out_word_last", 64'(out_word_last), 64'(e_front[OW]));
        chk("out_frame_last", 64'(out_frame_last), 64'(e_front[OW+1]));
        chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
        chk("busy", 64'(busy), 64'(e_busy));
        o_f = e_vld && ordy;
        i_f = iv && e_rdy;
        last_in_fire = i_f;
        if (o_f) begin
            obs_d.push_back(out_data); obs_wl.push_back(out_word_last);
            obs_fl.push_back(out_frame_last); obs_cyc.push_back(cyc);
            void'(exp_q.pop_front());
        end
        if (i_f) begin
            acc_cyc.push_back(cyc);
            if (m_wcnt == 0) m_flen = (cfg == 0) ? 1 : int'(cfg);
            len = m_flen;
            fin = (m_wcnt + 1 == len);
            m_wcnt = fin ? 0 : m_wcnt + 1;
            for (int i = 0; i < R; i++)
                exp_q.push_back({fin && (i == R-1), i == R-1, id[i*OW +: OW]});
        end
        @(posedge clk);
        cyc++;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
        #1;
        chk("rst out_vld", 64'(out_vld), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_word_last", 64'(out_word_last), 64'd0);
        chk("rst out_frame_last", 64'(out_frame_last), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        exp_q.delete();
        m_wcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_rdy", 64'(in_rdy), 64'd1);
    endtask

    // Feed n words back to back (out_rdy high) until want beats transferred.
    task automatic feed(input int n, input int want, input logic [FW-1:0] cfg1, input logic [FW-1:0] cfg2);
        int acc = 0;
        for (int c = 0; c < 400 && obs_d.size() < want; c++) begin
            step(acc < n, rnd_word(), 1'b1, (acc == 0) ? cfg1 : cfg2);
            if (last_in_fire) acc++;
        end
        chk("feed beat count", 64'(obs_d.size()), 64'(want));
    endtask

    initial begin
        int fl_cnt;
        int bp[4] = '{1, 0, 0, 1};
        int c;

        // reset state
        #1;
        chk("init out_vld", 64'(out_vld), 64'd0);
        chk("init out_data", 64'(out_data), 64'd0);
        chk("init busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init in_rdy", 64'(in_rdy), 64'd1);

        // single word, slices equal to their index
        clear_logs();
        step(1'b1, idx_word(0), 1'b1, 16'd1);
        repeat (R + 1) step(1'b0, '0, 1'b1, 16'd1);
        chk("single beats", 64'(obs_d.size()), 64'(R));
        if (obs_d.size() == R) begin
            chk("single latency", 64'(obs_cyc[0] - acc_cyc[0]), 64'd1);
            for (int i = 0; i < R; i++) begin
                chk("single data", 64'(obs_d[i]), 64'(i));
                chk("single word_last", 64'(obs_wl[i]), 64'(i == R-1));
                chk("single frame_last", 64'(obs_fl[i]), 64'(i == R-1));
            end
        end

        // back-to-back, 4-word frame
        clear_logs();
        feed(4, 32, 16'd4, 16'd4);
        if (obs_d.size() == 32) begin
            chk("b2b no gaps", 64'(obs_cyc[31] - obs_cyc[0]), 64'd31);
            fl_cnt = 0;
            foreach (obs_fl[i]) fl_cnt += int'(obs_fl[i]);
            chk("b2b frame_last count", 64'(fl_cnt), 64'd1);
            chk("b2b frame_last pos", 64'(obs_fl[31]), 64'd1);
            chk("b2b word_last 15", 64'(obs_wl[15]), 64'd1);
        end
        step(1'b0, '0, 1'b1, 16'd1);

        // backpressure 1,0,0,1
        clear_logs();
        c = 0;
        while (c < 100 && obs_d.size() < R) begin
            step(c == 0, idx_word(16), bp[c % 4] != 0, 16'd1);
            c++;
        end
        chk("bp beats", 64'(obs_d.size()), 64'(R));
        if (obs_d.size() == R)
            for (int i = 0; i < R; i++) chk("bp data order", 64'(obs_d[i]), 64'(16 + i));
        step(1'b0, '0, 1'b1, 16'd1);

        // frame length 3 then cfg changed to 5 mid-frame
        clear_logs();
        feed(8, 64, 16'd3, 16'd5);
        if (obs_d.size() == 64) begin
            fl_cnt = 0;
            foreach (obs_fl[i]) fl_cnt += int'(obs_fl[i]);
            chk("len35 frame_last count", 64'(fl_cnt), 64'd2);
            chk("len35 beat 23", 64'(obs_fl[23]), 64'd1);
            chk("len35 beat 63", 64'(obs_fl[63]), 64'd1);
        end
        step(1'b0, '0, 1'b1, 16'd1);

        // cfg_words = 0 behaves as one word per frame
        clear_logs();
        feed(2, 16, 16'd0, 16'd0);
        if (obs_d.size() == 16) begin
            chk("len0 beat 7", 64'(obs_fl[7]), 64'd1);
            chk("len0 beat 15", 64'(obs_fl[15]), 64'd1);
        end
        step(1'b0, '0, 1'b1, 16'd1);

        // reset during beat 3 of word 2 of a 4-word frame
        clear_logs();
        feed(4, 11, 16'd4, 16'd4);
        do_reset();
        clear_logs();
        step(1'b1, idx_word(64), 1'b1, 16'd2);
        repeat (R + 1) step(1'b0, '0, 1'b1, 16'd2);
        chk("post-rst beats", 64'(obs_d.size()), 64'(R));
        if (obs_d.size() == R) begin
            chk("post-rst slice0", 64'(obs_d[0]), 64'd64);
            chk("post-rst not frame end", 64'(obs_fl[R-1]), 64'd0);
        end
        // upstream empty with an open frame
        chk("open frame busy", 64'(busy), 64'd1);
        chk("open frame out_vld", 64'(out_vld), 64'd0);

        // randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 3) != 0,
                 FW'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
